gbuff_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port global buffer between several requesters (host loader, systolic-array operand feeder, result writeback). It accepts per-requester read/write requests, grants one access per cycle, drives the buffer's write-enable/index/data ports, and routes registered read data back to the granted requester with a valid strobe. Burst locking with a fairness cap lets a requester stream consecutive addresses without starving the others.

---
 rtl/gbuff_arbiter.sv | 127 ++++++++++++
 tb/tb_gbuff_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbuff_arbiter.sv
// Round-robin arbiter sharing the single-port global buffer.
// Burst locking with a fairness cap; registered read-data routing.
module gbuff_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int IDX_W     = 16,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 256,
    parameter int MAX_BURST = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*IDX_W-1:0]  idx,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic                      gb_wr_en,
    output logic [IDX_W-1:0]          gb_index,
    output logic [DATA_W-1:0]         gb_data_in,
    input  logic [DATA_W-1:0]         gb_data_out
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]  BURST_CAP = BW'(MAX_BURST);
    localparam logic [IDX_W:0] DEPTH_L   = (IDX_W + 1)'(DEPTH);
    localparam logic [PW-1:0]  LAST      = PW'(NUM_REQ - 1);

    logic [PW-1:0]      ptr, ptr_nxt;
    logic [PW-1:0]      owner, owner_nxt;
    logic               own_vld, own_vld_nxt;
    logic [BW-1:0]      burst_cnt, burst_nxt;
    logic [NUM_REQ-1:0] rvalid_q, gnt_w;
    logic               err_q;

    logic               other_req, cont, any;
    logic [PW-1:0]      gidx;
    logic [IDX_W-1:0]   sel_idx;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_we, sel_lock;
    logic               active, in_range, hit;

    always_comb begin
        int k;
        k         = 0;
        other_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (i != int'(owner))) other_req = 1'b1;
        end
        cont = own_vld && req[owner] &&
               ((burst_cnt < BURST_CAP) || !other_req);
        any  = 1'b0;
        gidx = '0;
        if (cont) begin
            any  = 1'b1;
            gidx = owner;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                k = int'(ptr) + i;
                if (k >= NUM_REQ) k = k - NUM_REQ;
                if (!any && req[k]) begin
                    any  = 1'b1;
                    gidx = PW'(k);
                end
            end
        end
        gnt_w = '0;
        if (any) gnt_w[gidx] = 1'b1;
    end

    assign sel_idx   = idx[int'(gidx)*IDX_W +: IDX_W];
    assign sel_wdata = wdata[int'(gidx)*DATA_W +: DATA_W];
    assign sel_we    = we[gidx];
    assign sel_lock  = lock[gidx];
    assign in_range  = {1'b0, sel_idx} < DEPTH_L;
    assign active    = any & rst_n;
    assign hit       = active & in_range;

    assign gnt        = active ? gnt_w : '0;
    assign gb_wr_en   = hit & sel_we;
    assign gb_index   = hit ? sel_idx : '0;
    assign gb_data_in = hit ? sel_wdata : '0;

    always_comb begin
        ptr_nxt     = ptr;
        owner_nxt   = owner;
        own_vld_nxt = 1'b0;
        burst_nxt   = '0;
        if (any && cont) begin
            own_vld_nxt = sel_lock;
            burst_nxt   = (burst_cnt == BURST_CAP) ? burst_cnt
                                                   : burst_cnt + BW'(1);
        end else if (any) begin
            ptr_nxt     = (gidx == LAST) ? '0 : gidx + PW'(1);
            owner_nxt   = gidx;
            own_vld_nxt = sel_lock;
            burst_nxt   = BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            owner     <= '0;
            own_vld   <= 1'b0;
            burst_cnt <= '0;
            rvalid_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            own_vld   <= own_vld_nxt;
            burst_cnt <= burst_nxt;
            rvalid_q  <= (hit && !sel_we) ? gnt_w : '0;
            err_q     <= active & ~in_range;
        end
    end

    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign rdata  = gb_data_out;

endmodule

// File: tb/tb_gbuff_arbiter.sv
// Bench for gbuff_arbiter: directed scenarios plus random traffic
// checked against a behavioural arbitration and memory model.
module tb_gbuff_arbiter;

    localparam int NR = 3;
    localparam int MB = 8;
    localparam int DP = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req = '0, we = '0, lock = '0;
    logic [NR*16-1:0] idx = '0;
    logic [NR*32-1:0] wdata = '0;
    logic [NR-1:0] gnt, rvalid;
    logic [31:0]   rdata, gb_data_in, gb_data_out;
    logic [15:0]   gb_index;
    logic          err, gb_wr_en;

    gbuff_arbiter #(
        .NUM_REQ(NR), .IDX_W(16), .DATA_W(32), .DEPTH(DP), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock),
        .idx(idx), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .err(err), .gb_wr_en(gb_wr_en),
        .gb_index(gb_index), .gb_data_in(gb_data_in),
        .gb_data_out(gb_data_out)
    );

    always #5 clk = ~clk;

    // buffer: write and registered read on the same edge
    logic [31:0] ram [DP];
    always @(posedge clk) begin
        if (gb_wr_en) ram[gb_index[7:0]] <= gb_data_in;
        gb_data_out <= ram[gb_index[7:0]];
    end

    int checks = 0, errors = 0;

    // reference model
    logic [31:0] exp_mem [DP];
    int m_ptr = 0, m_owner = -1, m_burst = 0;
    int m_pend = -1;
    logic [31:0] m_pdata = '0;
    bit m_perr = 0;
    int m_g = -1, last_g = -1;
    bit m_cont = 0, m_inr = 0;
    logic [NR-1:0] e_gnt, e_rv;
    logic [31:0]   e_rdata, e_gdata;
    logic [15:0]   e_gidx, m_idx;
    logic          e_err, e_wen;

    task automatic eval();
        bit others;
        int k;
        @(negedge clk);
        m_g = -1; m_cont = 0; m_inr = 0;
        if (rst_n) begin
            others = 0;
            for (int i = 0; i < NR; i++)
                if (i != m_owner && req[i]) others = 1;
            if (m_owner >= 0 && req[m_owner] && (m_burst < MB || !others)) begin
                m_g = m_owner; m_cont = 1;
            end else begin
                for (int i = 0; i < NR; i++) begin
                    k = (m_ptr + i) % NR;
                    if (m_g < 0 && req[k]) m_g = k;
                end
            end
        end
        e_gnt = '0; e_wen = 0; e_gidx = '0; e_gdata = '0; m_idx = '0;
        if (m_g >= 0) begin
            e_gnt = NR'(1 << m_g);
            m_idx = idx[m_g*16 +: 16];
            m_inr = (int'(m_idx) < DP);
            if (m_inr) begin
                e_wen = we[m_g];
                e_gidx = m_idx;
                e_gdata = wdata[m_g*32 +: 32];
            end
        end
        e_rv = (rst_n && m_pend >= 0) ? NR'(1 << m_pend) : '0;
        e_rdata = m_pdata;
        e_err = rst_n && m_perr;
    endtask

    task automatic tick();
        if (!rst_n) begin
            m_ptr = 0; m_owner = -1; m_burst = 0; m_pend = -1; m_perr = 0;
        end else begin
            m_pend = -1; m_perr = 0;
            if (m_g >= 0) begin
                if (!m_inr) m_perr = 1;
                else if (we[m_g]) exp_mem[m_idx] = wdata[m_g*32 +: 32];
                else begin m_pend = m_g; m_pdata = exp_mem[m_idx]; end
                if (m_cont) begin
                    if (m_burst < MB) m_burst++;
                    if (!lock[m_g]) m_owner = -1;
                end else begin
                    m_ptr = (m_g + 1) % NR;
                    m_burst = 1;
                    m_owner = lock[m_g] ? m_g : -1;
                end
            end else begin
                m_owner = -1; m_burst = 0;
            end
        end
        last_g = m_g;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; req = '0; we = '0; lock = '0;
        eval(); tick();
        rst_n = 1;
    endtask

    task automatic set_req(int k, bit w, bit l, int ix, logic [31:0] d);
        req[k] = 1; we[k] = w; lock[k] = l;
        idx[k*16 +: 16] = 16'(ix);
        wdata[k*32 +: 32] = d;
    endtask

    task automatic test_reset();
        eval();
        checks++;
        if ({gnt, rvalid, err, gb_wr_en, gb_index, gb_data_in} !== '0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b rv=%b err=%b wen=%b ix=%h d=%h want all 0",
                     gnt, rvalid, err, gb_wr_en, gb_index, gb_data_in);
        end
        tick();
        rst_n = 1;
        set_req(0, 0, 0, 3, 32'h0);
        eval();
        checks++;
        if (gnt !== 3'b001) begin
            errors++; $display("FAIL reset_pre_read: gnt=%b want 001", gnt);
        end
        tick();
        rst_n = 0;
        eval();
        checks++;
        if (rvalid !== '0 || gnt !== '0 || gb_wr_en !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_read: rv=%b gnt=%b wen=%b err=%b want 0",
                     rvalid, gnt, gb_wr_en, err);
        end
        tick();
        rst_n = 1;
        req = 3'b111; we = '0; lock = '0;
        eval();
        checks++;
        if (gnt !== 3'b001) begin
            errors++; $display("FAIL reset_first_gnt: gnt=%b want 001", gnt);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] wg, wr;
        do_reset();
        for (int k = 0; k < NR; k++) set_req(k, 0, 0, k + 1, 32'h0);
        for (int c = 0; c < 5; c++) begin
            eval();
            wg = (c < 4) ? NR'(1 << (c % 3)) : '0;
            wr = (c == 0) ? '0 : NR'(1 << ((c - 1) % 3));
            if (c < 4) begin
                checks++;
                if (gnt !== wg) begin
                    errors++; $display("FAIL rr_gnt c=%0d: gnt=%b want %b", c, gnt, wg);
                end
            end
            checks++;
            if (rvalid !== wr) begin
                errors++; $display("FAIL rr_rvalid c=%0d: rv=%b want %b", c, rvalid, wr);
            end
            if (c > 0) begin
                checks++;
                if (rdata !== exp_mem[c - 1 - ((c - 1) / 3) * 3 + 1]) begin
                    errors++; $display("FAIL rr_rdata c=%0d: %h want %h", c, rdata,
                                       exp_mem[(c - 1) % 3 + 1]);
                end
            end
            tick();
            if (c == 3) req = '0;
        end
    endtask

    task automatic test_write_read();
        do_reset();
        set_req(0, 1, 0, 5, 32'hDEADBEEF);
        eval();
        checks++;
        if (gnt !== 3'b001 || gb_wr_en !== 1'b1 || gb_index !== 16'd5 ||
            gb_data_in !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_drive: gnt=%b wen=%b ix=%h d=%h want 001 1 0005 deadbeef",
                     gnt, gb_wr_en, gb_index, gb_data_in);
        end
        tick();
        req[0] = 0;
        set_req(1, 0, 0, 5, 32'h0);
        eval();
        checks++;
        if (gnt !== 3'b010) begin
            errors++; $display("FAIL rd_gnt: gnt=%b want 010", gnt);
        end
        tick();
        req = '0;
        eval();
        checks++;
        if (rvalid !== 3'b010 || rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_rd_data: rv=%b rdata=%h want 010 deadbeef", rvalid, rdata);
        end
        tick();
    endtask

    task automatic test_burst_cap();
        int ix;
        logic [NR-1:0] wg;
        do_reset();
        ix = 0;
        set_req(0, 0, 1, ix, 32'h0);
        for (int c = 0; c < 10; c++) begin
            if (c == 2) set_req(2, 0, 0, 50, 32'h0);
            eval();
            wg = (c == 8) ? 3'b100 : 3'b001;
            checks++;
            if (gnt !== wg) begin
                errors++; $display("FAIL burst_cap c=%0d: gnt=%b want %b", c, gnt, wg);
            end
            tick();
            if (last_g == 0) begin ix++; idx[15:0] = 16'(ix); end
            if (last_g == 2) req[2] = 0;
        end
        req = '0; lock = '0;
    endtask

    task automatic test_lock_alone();
        int ix;
        do_reset();
        ix = 100;
        set_req(0, 0, 1, ix, 32'h0);
        for (int c = 0; c < 20; c++) begin
            eval();
            checks++;
            if (gnt !== 3'b001) begin
                errors++; $display("FAIL lock_alone c=%0d: gnt=%b want 001", c, gnt);
            end
            tick();
            ix++; idx[15:0] = 16'(ix);
        end
        req = '0; lock = '0;
    endtask

    task automatic test_out_of_range();
        logic [31:0] w0;
        do_reset();
        w0 = exp_mem[0];
        set_req(1, 1, 0, 256, 32'h12345678);
        eval();
        checks++;
        if (gnt !== 3'b010 || gb_wr_en !== 1'b0 || gb_index !== 16'd0) begin
            errors++;
            $display("FAIL oor_drive: gnt=%b wen=%b ix=%h want 010 0 0000",
                     gnt, gb_wr_en, gb_index);
        end
        tick();
        req = '0;
        set_req(0, 0, 0, 0, 32'h0);
        eval();
        checks++;
        if (err !== 1'b1 || rvalid !== '0) begin
            errors++; $display("FAIL oor_err: err=%b rv=%b want 1 000", err, rvalid);
        end
        tick();
        req = '0;
        eval();
        checks++;
        if (rvalid !== 3'b001 || rdata !== w0 || err !== 1'b0) begin
            errors++;
            $display("FAIL oor_readback: rv=%b rdata=%h err=%b want 001 %h 0",
                     rvalid, rdata, err, w0);
        end
        tick();
    endtask

    task automatic test_random();
        bit rst_pulse;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NR; k++) begin
                if (k == last_g || !req[k]) begin
                    if ($urandom_range(0, 3) != 0)
                        set_req(k, 1'($urandom_range(0, 1)),
                                (k == 0) ? ($urandom_range(0, 3) != 0)
                                         : 1'($urandom_range(0, 1)),
                                ($urandom_range(0, 9) == 0) ? $urandom_range(256, 300)
                                                            : $urandom_range(0, 15),
                                $urandom);
                    else
                        req[k] = 0;
                end
            end
            rst_pulse = ($urandom_range(0, 299) == 0);
            if (rst_pulse) rst_n = 0;
            eval();
            checks++;
            if (gnt !== e_gnt) begin
                errors++; $display("FAIL rnd_gnt c=%0d: %b want %b", c, gnt, e_gnt);
            end
            checks++;
            if (rvalid !== e_rv) begin
                errors++; $display("FAIL rnd_rvalid c=%0d: %b want %b", c, rvalid, e_rv);
            end
            checks++;
            if (err !== e_err) begin
                errors++; $display("FAIL rnd_err c=%0d: %b want %b", c, err, e_err);
            end
            checks++;
            if (gb_wr_en !== e_wen || gb_index !== e_gidx || gb_data_in !== e_gdata) begin
                errors++;
                $display("FAIL rnd_buf c=%0d: wen=%b ix=%h d=%h want %b %h %h",
                         c, gb_wr_en, gb_index, gb_data_in, e_wen, e_gidx, e_gdata);
            end
            if (e_rv != '0) begin
                checks++;
                if (rdata !== e_rdata) begin
                    errors++; $display("FAIL rnd_rdata c=%0d: %h want %h", c, rdata, e_rdata);
                end
            end
            tick();
            if (rst_pulse) begin rst_n = 1; last_g = -1; end
        end
        req = '0; lock = '0;
    endtask

    initial begin
        for (int i = 0; i < DP; i++) begin
            ram[i] = $urandom;
            exp_mem[i] = ram[i];
        end
        test_reset();
        test_round_robin();
        test_write_read();
        test_burst_cap();
        test_lock_alone();
        test_out_of_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
